// File: rtl/if_id_pipe_reg_if.sv
// IF -> ID handshake bundle for if_id_pipe_reg. Includes the bubble counter
// output only when IF_ID_BUBBLE_CNT_EN is defined.
interface if_id_pipe_reg_if #(
    parameter int XLEN       = 32,
    parameter int INST_WIDTH = 32
) ();
    logic                  if_valid_i;
    logic [XLEN-1:0]       if_pc_i;
    logic [INST_WIDTH-1:0] if_inst_i;
    logic                  if_ready_o;
    logic                  flush_i;
    logic                  id_valid_o;
    logic [XLEN-1:0]       id_pc_o;
    logic [XLEN-1:0]       id_pc_plus4_o;
    logic [INST_WIDTH-1:0] id_inst_o;
    logic                  id_ready_i;
`ifdef IF_ID_BUBBLE_CNT_EN
    logic [31:0]           perf_bubble_cnt_o;
`endif

    // The pipe register is the slave; fetch/decode/branch logic form the master side.
    modport slave (
        input  if_valid_i, if_pc_i, if_inst_i, flush_i, id_ready_i,
        output if_ready_o, id_valid_o, id_pc_o, id_pc_plus4_o, id_inst_o
`ifdef IF_ID_BUBBLE_CNT_EN
        , output perf_bubble_cnt_o
`endif
    );

    modport master (
        output if_valid_i, if_pc_i, if_inst_i, flush_i, id_ready_i,
        input  if_ready_o, id_valid_o, id_pc_o, id_pc_plus4_o, id_inst_o
`ifdef IF_ID_BUBBLE_CNT_EN
        , input perf_bubble_cnt_o
`endif
    );
endinterface

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register with a 2-entry skid buffer (main + skid).
// Optional decode-bubble counter enabled by IF_ID_BUBBLE_CNT_EN.
module if_id_pipe_reg #(
    parameter int                    XLEN       = 32,
    parameter int                    INST_WIDTH = 32,
    parameter logic [INST_WIDTH-1:0] NOP_INST   = 32'h0000_0013
) (
    input  logic           clk,
    input  logic           rst,
    if_id_pipe_reg_if.slave bus
);

    // State bits are {main_valid, skid_valid}; 2'b01 can never be reached.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        FULL  = 2'b11
    } state_t;

    state_t                state, state_n;
    logic [XLEN-1:0]       main_pc, skid_pc;
    logic [INST_WIDTH-1:0] main_inst, skid_inst;
    logic                  main_valid, skid_valid;
    logic                  accept, drain;
    logic                  load_main_in, load_main_skid, load_skid_in;

    assign main_valid = state[1];
    assign skid_valid = state[0];

    // Ready comes from registered state only, so ID stall never reaches pc_we combinationally.
    assign bus.if_ready_o = ~skid_valid;
    assign accept         = bus.if_valid_i & ~skid_valid;
    assign drain          = main_valid & bus.id_ready_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= EMPTY;
        else     state <= state_n;
    end

    always_comb begin
        state_n        = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid_in   = 1'b0;
        if (bus.flush_i) begin
            state_n = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state_n      = ONE;
                        load_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        load_main_in = 1'b1;
                    end else if (accept) begin
                        state_n      = FULL;
                        load_skid_in = 1'b1;
                    end else if (drain) begin
                        state_n = EMPTY;
                    end
                end
                FULL: begin
                    if (drain) begin
                        state_n        = ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_n = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_pc   <= '0;
            main_inst <= NOP_INST;
            skid_pc   <= '0;
            skid_inst <= NOP_INST;
        end else begin
            if (load_main_in) begin
                main_pc   <= bus.if_pc_i;
                main_inst <= bus.if_inst_i;
            end else if (load_main_skid) begin
                main_pc   <= skid_pc;
                main_inst <= skid_inst;
            end
            if (load_skid_in) begin
                skid_pc   <= bus.if_pc_i;
                skid_inst <= bus.if_inst_i;
            end
        end
    end

    // PC registers keep their last value after drain; only the instruction reverts to NOP.
    assign bus.id_valid_o    = main_valid;
    assign bus.id_pc_o       = main_pc;
    assign bus.id_pc_plus4_o = main_pc + XLEN'(4);
    assign bus.id_inst_o     = main_valid ? main_inst : NOP_INST;

`ifdef IF_ID_BUBBLE_CNT_EN
    logic [31:0] bubble_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                 bubble_cnt <= '0;
        else if (!main_valid && bubble_cnt != '1) bubble_cnt <= bubble_cnt + 32'd1;
    end

    assign bus.perf_bubble_cnt_o = bubble_cnt;
`endif

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Directed self-checking bench for if_id_pipe_reg (streaming, back-pressure,
// flush, PC wrap, async reset, and the bubble counter when enabled).
module tb_if_id_pipe_reg;
    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    if_id_pipe_reg_if #(.XLEN(32), .INST_WIDTH(32)) bus ();

    if_id_pipe_reg #(.XLEN(32), .INST_WIDTH(32), .NOP_INST(32'h0000_0013)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic v, input logic [31:0] pc, input logic [31:0] inst);
        bus.if_valid_i = v;
        bus.if_pc_i    = pc;
        bus.if_inst_i  = inst;
    endtask

    initial begin
        rst            = 1'b1;
        bus.flush_i    = 1'b0;
        bus.id_ready_i = 1'b0;
        present(1'b0, 32'h0, 32'h0);

        // Reset values before any clock edge
        #3;
        chk("rst_valid", 64'(bus.id_valid_o), 64'd0);
        chk("rst_inst", 64'(bus.id_inst_o), 64'h13);
        chk("rst_pc", 64'(bus.id_pc_o), 64'd0);
        chk("rst_pc4", 64'(bus.id_pc_plus4_o), 64'd4);
        chk("rst_ready", 64'(bus.if_ready_o), 64'd1);
        #5;
        rst = 1'b0;

`ifdef IF_ID_BUBBLE_CNT_EN
        repeat (5) tick();
        chk("bubble_5", 64'(bus.perf_bubble_cnt_o), 64'd5);
`endif

        // Streaming with ID always ready
        bus.id_ready_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            present(1'b1, 32'(4 * i), 32'(i));
            tick();
            chk($sformatf("stream_valid_%0d", i), 64'(bus.id_valid_o), 64'd1);
            chk($sformatf("stream_inst_%0d", i), 64'(bus.id_inst_o), 64'(i));
            chk($sformatf("stream_pc4_%0d", i), 64'(bus.id_pc_plus4_o), 64'(4 * i + 4));
            chk($sformatf("stream_ready_%0d", i), 64'(bus.if_ready_o), 64'd1);
        end
        present(1'b0, 32'h0, 32'h0);
        tick();
        chk("stream_end_valid", 64'(bus.id_valid_o), 64'd0);
        chk("stream_end_inst", 64'(bus.id_inst_o), 64'h13);
        chk("stream_end_pc_hold", 64'(bus.id_pc_o), 64'd36);
        chk("stream_end_pc4_hold", 64'(bus.id_pc_plus4_o), 64'd40);

        // Back-pressure fill: A then B, then C is refused
        bus.id_ready_i = 1'b0;
        present(1'b1, 32'h10, 32'hAAAA_0001);
        tick();
        chk("fill_a_inst", 64'(bus.id_inst_o), 64'hAAAA_0001);
        chk("fill_a_ready", 64'(bus.if_ready_o), 64'd1);
        present(1'b1, 32'h14, 32'hBBBB_0002);
        tick();
        chk("full_ready", 64'(bus.if_ready_o), 64'd0);
        chk("full_inst_a", 64'(bus.id_inst_o), 64'hAAAA_0001);
        chk("full_pc_a", 64'(bus.id_pc_o), 64'h10);
        present(1'b1, 32'h18, 32'hCCCC_0003);
        tick();
        chk("c_refused_inst", 64'(bus.id_inst_o), 64'hAAAA_0001);
        chk("c_refused_ready", 64'(bus.if_ready_o), 64'd0);

        // Drain: A consumed, B shows, then empty
        present(1'b0, 32'h0, 32'h0);
        bus.id_ready_i = 1'b1;
        tick();
        chk("drain_b_inst", 64'(bus.id_inst_o), 64'hBBBB_0002);
        chk("drain_b_pc", 64'(bus.id_pc_o), 64'h14);
        chk("drain_b_valid", 64'(bus.id_valid_o), 64'd1);
        chk("drain_b_ready", 64'(bus.if_ready_o), 64'd1);
        tick();
        chk("drain_empty_valid", 64'(bus.id_valid_o), 64'd0);
        chk("drain_empty_inst", 64'(bus.id_inst_o), 64'h13);

        // Flush while FULL with a same-cycle fetch
        bus.id_ready_i = 1'b0;
        present(1'b1, 32'h20, 32'hDDDD_0004);
        tick();
        present(1'b1, 32'h24, 32'hEEEE_0005);
        tick();
        chk("pre_flush_ready", 64'(bus.if_ready_o), 64'd0);
        present(1'b1, 32'h40, 32'hFFFF_0006);
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        present(1'b0, 32'h0, 32'h0);
        chk("flush_valid", 64'(bus.id_valid_o), 64'd0);
        chk("flush_ready", 64'(bus.if_ready_o), 64'd1);
        chk("flush_inst", 64'(bus.id_inst_o), 64'h13);
        chk("flush_pc_hold", 64'(bus.id_pc_o), 64'h20);
        bus.id_ready_i = 1'b1;
        tick();
        chk("flush_no_0x40_valid", 64'(bus.id_valid_o), 64'd0);
        chk("flush_no_0x40_pc", 64'(bus.id_pc_o), 64'h20);

        // PC+4 wrap
        bus.id_ready_i = 1'b0;
        present(1'b1, 32'hFFFF_FFFC, 32'h1234_5678);
        tick();
        present(1'b0, 32'h0, 32'h0);
        chk("wrap_valid", 64'(bus.id_valid_o), 64'd1);
        chk("wrap_pc", 64'(bus.id_pc_o), 64'hFFFF_FFFC);
        chk("wrap_pc4", 64'(bus.id_pc_plus4_o), 64'd0);
        chk("wrap_inst", 64'(bus.id_inst_o), 64'h1234_5678);

        // Async reset mid-operation, no clock edge in between
        rst = 1'b1;
        #2;
        chk("async_rst_valid", 64'(bus.id_valid_o), 64'd0);
        chk("async_rst_pc", 64'(bus.id_pc_o), 64'd0);
        chk("async_rst_pc4", 64'(bus.id_pc_plus4_o), 64'd4);
        chk("async_rst_inst", 64'(bus.id_inst_o), 64'h13);
        chk("async_rst_ready", 64'(bus.if_ready_o), 64'd1);
`ifdef IF_ID_BUBBLE_CNT_EN
        chk("async_rst_bubble", 64'(bus.perf_bubble_cnt_o), 64'd0);
`endif
        rst = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/if_id_pipe_reg.md
Name: if_id_pipe_reg

Overview:
Pipeline register between IF_stage and the decode stage of the RISC-V core.
- Captures each fetched instruction and its PC, and presents them to ID one cycle later.
- A 2-entry skid buffer decouples ID back-pressure from the fetch path. if_ready_o has no combinational path from id_ready_i.
- if_ready_o drives IF_stage pc_we. flush_i from the branch-resolution logic kills in-flight fetches.

Parameters:
XLEN, 32, width of PC and of PC+4 arithmetic
INST_WIDTH, 32, instruction word width
NOP_INST, 32'h0000_0013, word driven on id_inst_o when no valid entry (addi x0,x0,0)

Ports:
clk  in  1  core clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
if_valid_i  in  1  IF presents a valid instruction this cycle
if_pc_i  in  XLEN  PC of the presented instruction
if_inst_i  in  INST_WIDTH  fetched instruction word
if_ready_o  out  1  register can accept; drives IF pc_we
flush_i  in  1  discard all held and incoming instructions
id_valid_o  out  1  id_* outputs hold a valid instruction
id_pc_o  out  XLEN  PC of the presented instruction
id_pc_plus4_o  out  XLEN  id_pc_o + 4
id_inst_o  out  INST_WIDTH  instruction to decode
id_ready_i  in  1  ID consumes the presented instruction this cycle

Behaviour:
- State is main_valid and skid_valid. Main entry drives id_*. The skid entry holds one overflow instruction.
- Encoded states: EMPTY(0,0), ONE(1,0), FULL(1,1). State (0,1) is illegal and unreachable.
- accept = if_valid_i & if_ready_o. drain = main_valid & id_ready_i.
- if_ready_o = ~skid_valid, derived from registered state only.
- Transitions when flush_i = 0:
  - EMPTY: accept -> ONE, main <= input. Otherwise stay in EMPTY.
  - ONE: accept & drain -> ONE, main <= input. accept & ~drain -> FULL, skid <= input. ~accept & drain -> EMPTY. Neither -> hold.
  - FULL: drain -> ONE, main <= skid. No accept is possible (if_ready_o = 0). Otherwise hold.
- flush_i = 1: next state is EMPTY unconditionally.
  - A same-cycle accept is discarded.
  - A same-cycle drain still counts as consumed by ID.
  - if_ready_o is 1 on the following cycle.
- Latency: an instruction accepted at edge N appears on id_* after edge N, if no older entry is ahead of it.
- Program order is strictly preserved. No instruction is dropped or duplicated except by flush_i.
- id_* outputs are stable while id_valid_o = 1 and id_ready_i = 0.
- id_valid_o = 0: id_inst_o = NOP_INST. id_pc_o and id_pc_plus4_o hold their last values.
- id_pc_plus4_o = id_pc_o + 4, truncated to XLEN. Wraps: 32'hFFFF_FFFC -> 32'h0000_0000.
- if_valid_i = 0 with if_ready_o = 1 is legal and leaves state unchanged.
- Reset (async assert, synchronous release point irrelevant to this block):
  - main_valid = skid_valid = 0.
  - id_valid_o = 0, id_inst_o = NOP_INST, id_pc_o = 0, id_pc_plus4_o = 4, if_ready_o = 1.
- Reset asserted mid-operation discards all entries immediately, with no clock required.

Optional Feature:
IF_ID_BUBBLE_CNT_EN
- Defined:
  - Adds output perf_bubble_cnt_o [31:0].
  - The counter increments on every clock edge where rst = 0 and id_valid_o = 0.
  - Saturates at 32'hFFFF_FFFF.
  - Async reset to 0. Unaffected by flush_i.
- Not defined: the port and counter do not exist. Behaviour is otherwise identical.

Test Plan:
- Reset, then check outputs with no clock: id_valid_o = 0, id_inst_o = 32'h0000_0013, id_pc_plus4_o = 4, if_ready_o = 1.
- Streaming: id_ready_i = 1; present pc = 0,4,...,36 with inst = 0..9 on consecutive cycles -> id_inst_o = 0..9 one cycle later in order; if_ready_o stays 1; id_pc_plus4_o = pc+4.
- Back-pressure, fill:
  - Present inst A (pc 0x10) then B (pc 0x14) with id_ready_i = 0.
  - Expect FULL, if_ready_o = 0, and id_inst_o holding A.
  - Present C while if_ready_o = 0 -> C is not captured.
- Back-pressure, drain: from FULL, raise id_ready_i for two cycles -> A, then B, then id_valid_o = 0; C is not presented.
- Flush: in FULL, assert flush_i together with if_valid_i (pc 0x40) -> next cycle id_valid_o = 0, if_ready_o = 1, and pc 0x40 never appears.
- Wrap, and bubble counter if IF_ID_BUBBLE_CNT_EN is defined:
  - Accept pc = 32'hFFFF_FFFC -> id_pc_plus4_o = 0.
  - With the macro, 5 idle cycles after reset -> perf_bubble_cnt_o = 5.
